pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder.sv | 149 ++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow.
// Stage 1 forms group generate/propagate, stage 2 resolves carries and flags.
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int NG  = WIDTH / GROUP;
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] p0;
  logic [NG-1:0]    gg0;
  logic [NG-1:0]    pp0;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_bx;
  logic             s1_cin;
  logic [NG-1:0]    s1_gg;
  logic [NG-1:0]    s1_pp;

  logic [WIDTH-1:0] g1;
  logic [WIDTH-1:0] p1;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] bc;
  logic [WIDTH-1:0] sum_n;
  logic             ovf_n;
  logic             s2_load;

  assign bx = Sub ? ~B : B;
  assign g0 = A & bx;
  assign p0 = A ^ bx;

  // Group G is the sum-of-products lookahead over the group's bits.
  always_comb begin : grp_gp
    logic t;
    t   = 1'b0;
    gg0 = '0;
    pp0 = '1;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        t = g0[k*GROUP+i];
        for (int j = i + 1; j < GROUP; j++)
          t = t & p0[k*GROUP+j];
        gg0[k] = gg0[k] | t;
        pp0[k] = pp0[k] & p0[k*GROUP+i];
      end
    end
  end

  assign s2_load  = !out_valid | out_ready;
  assign in_ready = !s1_valid | s2_load;

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_a   <= A;
      s1_bx  <= bx;
      s1_cin <= Cin;
      s1_gg  <= gg0;
      s1_pp  <= pp0;
    end
  end

  assign g1 = s1_a & s1_bx;
  assign p1 = s1_a ^ s1_bx;

  // Every group carry is a flat product-of-terms; nothing ripples between groups.
  always_comb begin : grp_carry
    logic t;
    t  = 1'b0;
    gc = '0;
    for (int k = 0; k <= NG; k++) begin
      t = s1_cin;
      for (int m = 0; m < k; m++)
        t = t & s1_pp[m];
      gc[k] = t;
      for (int j = 0; j < k; j++) begin
        t = s1_gg[j];
        for (int m = j + 1; m < k; m++)
          t = t & s1_pp[m];
        gc[k] = gc[k] | t;
      end
    end
  end

  always_comb begin : bit_carry
    logic t;
    t  = 1'b0;
    bc = '0;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        t = gc[k];
        for (int m = 0; m < i; m++)
          t = t & p1[k*GROUP+m];
        bc[k*GROUP+i] = t;
        for (int j = 0; j < i; j++) begin
          t = g1[k*GROUP+j];
          for (int m = j + 1; m < i; m++)
            t = t & p1[k*GROUP+m];
          bc[k*GROUP+i] = bc[k*GROUP+i] | t;
        end
      end
    end
  end

  assign sum_n = p1 ^ bc;
  assign ovf_n = (s1_a[MSB] == s1_bx[MSB]) &
                 (sum_n[MSB] != s1_a[MSB]);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      Zero      <= 1'b0;
    end else begin
      if (in_ready)
        s1_valid <= in_valid;
      if (s2_load)
        out_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        Sum  <= sum_n;
        Cout <= gc[NG];
        Ovf  <= ovf_n;
        Zero <= ~|sum_n;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vectors, stall/reset sequences
// and a random stream scored against an arithmetic reference model.
module tb_pipelined_cla_adder;

  localparam int W  = 32;
  localparam int G  = 4;
  localparam int NG = W / G;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    res_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;
  logic         Zero;

  int checks   = 0;
  int errors   = 0;
  int accepted = 0;
  logic acc_last = 1'b0;
  logic stall_prev = 1'b0;
  logic [W+2:0] held;
  res_t q[$];

  pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf), .Zero(Zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic res_t mk(input logic [W-1:0] s, input logic c,
                              input logic o, input logic z);
    res_t r;
    r.sum = s; r.cout = c; r.ovf = o; r.zero = z;
    return r;
  endfunction

  // Unsigned sum for Sum/Cout, exact signed sum for overflow.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    logic [W-1:0] bx;
    logic [W:0] u;
    longint s;
    longint lim;
    bx  = sub ? ~b : b;
    u   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
    s   = longint'($signed(a)) + longint'($signed(bx)) + longint'(cin);
    lim = longint'(1) << (W - 1);
    r.sum  = u[W-1:0];
    r.cout = u[W];
    r.ovf  = (s >= lim) || (s < -lim);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  task automatic cmp_res(input string nm, input res_t e);
    checks++;
    if ({Sum, Cout, Ovf, Zero} !== {e.sum, e.cout, e.ovf, e.zero}) begin
      errors++;
      $display("FAIL %s: got sum=%h cout=%b ovf=%b zero=%b, need sum=%h cout=%b ovf=%b zero=%b",
               nm, Sum, Cout, Ovf, Zero, e.sum, e.cout, e.ovf, e.zero);
    end
  endtask

  task automatic cmp_bit(input string nm, input logic got, input logic e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got %b, need %b", nm, got, e);
    end
  endtask

  // Scoreboard: every accepted operand set must come out once, in order.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      stall_prev = 1'b0;
      acc_last = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if ({Sum, Cout, Ovf, Zero} !== held) begin
          errors++;
          $display("FAIL stall_stable: got %h, need %h",
                   {Sum, Cout, Ovf, Zero}, held);
        end
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result: got sum=%h, need no result", Sum);
        end else begin
          cmp_res("stream", q.pop_front());
        end
      end
      acc_last = in_valid && in_ready;
      if (acc_last) begin
        q.push_back(model(A, B, Cin, Sub));
        accepted++;
      end
      stall_prev = out_valid && !out_ready;
      held = {Sum, Cout, Ovf, Zero};
    end
  end

  task automatic run_one(input string nm, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin,
                         input logic sub, input res_t e);
    @(posedge clk); #1;
    in_valid = 1'b1; A = a; B = b; Cin = cin; Sub = sub;
    @(negedge clk);
    cmp_bit({nm, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    cmp_bit({nm, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    cmp_bit({nm, "_valid"}, out_valid, 1'b1);
    cmp_res(nm, e);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      default: return $urandom();
    endcase
  endfunction

  vec_t tbl[9];
  logic [W-1:0] sb;
  int target;
  int cyc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;

    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, mk(32'h00000000, 1, 0, 1)};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, mk(32'h80000000, 0, 1, 0)};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, mk(32'hFFFFFFFE, 0, 0, 0)};
    tbl[3] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, mk(32'h00000000, 0, 0, 1)};
    tbl[4] = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, mk(32'h00000000, 1, 0, 1)};
    tbl[5] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, mk(32'h7FFFFFFF, 1, 1, 0)};
    tbl[6] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, mk(32'hFFFFFFFD, 0, 0, 0)};
    tbl[7] = '{32'h00000001, 32'h00000001, 1'b1, 1'b0, mk(32'h00000003, 0, 0, 0)};
    tbl[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, mk(32'h00000000, 1, 1, 1)};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    cmp_bit("rst_out_valid", out_valid, 1'b0);
    cmp_bit("rst_in_ready", in_ready, 1'b1);
    cmp_res("rst_data", mk('0, 0, 0, 0));

    out_ready = 1'b1;
    for (int i = 0; i < 9; i++)
      run_one($sformatf("vec%0d", i), tbl[i].a, tbl[i].b,
              tbl[i].cin, tbl[i].sub, tbl[i].exp);

    for (int k = 0; k < NG; k++)
      run_one($sformatf("grp%0d", k), 32'hF << (G*k), 32'h1 << (G*k),
              1'b0, 1'b0,
              mk(32'h10 << (G*k), k == NG-1, 1'b0, k == NG-1));

    // Back-pressure: three ops into a stalled pipe.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; A = 1; B = 2; Cin = 0; Sub = 0;
    @(negedge clk);
    cmp_bit("bp_acc0", in_ready, 1'b1);
    @(posedge clk); #1;
    A = 3; B = 4;
    @(negedge clk);
    cmp_bit("bp_acc1", in_ready, 1'b1);
    @(posedge clk); #1;
    A = 10; B = 20;
    @(negedge clk);
    cmp_bit("bp_ready_drop", in_ready, 1'b0);
    sb = Sum;
    repeat (3) begin
      @(negedge clk);
      cmp_bit("bp_hold_valid", out_valid, 1'b1);
      cmp_bit("bp_hold_ready", in_ready, 1'b0);
      cmp_res("bp_hold", mk(32'd3, 0, 0, 0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    cmp_bit("bp_out0_v", out_valid, 1'b1);
    cmp_res("bp_out0", mk(32'd3, 0, 0, 0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    cmp_bit("bp_out1_v", out_valid, 1'b1);
    cmp_res("bp_out1", mk(32'd7, 0, 0, 0));
    @(negedge clk);
    cmp_bit("bp_out2_v", out_valid, 1'b1);
    cmp_res("bp_out2", mk(32'd30, 0, 0, 0));
    @(negedge clk);
    cmp_bit("bp_empty", out_valid, 1'b0);

    // Reset with two ops in flight, in_valid held high during reset.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; A = 100; B = 1;
    @(posedge clk); #1;
    A = 200; B = 2;
    @(posedge clk); #1;
    A = 300; B = 3; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    cmp_bit("mid_rst_valid", out_valid, 1'b0);
    cmp_bit("mid_rst_ready", in_ready, 1'b1);
    repeat (6) begin
      @(negedge clk);
      cmp_bit("mid_rst_ghost", out_valid, 1'b0);
    end

    // Random stream with random handshakes.
    target = accepted + 2000;
    cyc = 0;
    while (accepted < target && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (!in_valid || acc_last) begin
        in_valid = ($urandom_range(0, 3) != 0);
        A = pick(); B = pick();
        Cin = 1'($urandom_range(0, 1));
        Sub = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    cmp_bit("rand_budget", accepted >= target, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, need 0", q.size());
    end
    cmp_bit("drain_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
